// File: rtl/ay_stereo_mixer_dac.sv
// rtl/ay_stereo_mixer_dac.sv - AY turbosound stereo mixer with sigma-delta 1-bit DACs
//
// Purpose: mixes six 8-bit AY channel levels (two chips) plus the beeper bit
// into left/right sums with a time-multiplexed accumulator (8-slot frame at
// clk28), then drives two first-order sigma-delta bitstreams for the board's
// RC audio filters.
//
// Optional feature macro: AY_MIXER_BEEPER_EN
//   defined   - slot 6 adds 255 to both sums when beeper = 1
//   undefined - beeper input is ignored
//
// Ports:
//   clk28                 system clock, 28 MHz
//   rst_n                 asynchronous active-low reset
//   en                    1 = audio enabled, 0 = samples forced to 0
//   stereo_mode[1:0]      0 mono, 1 ABC, 2 ACB, 3 mono
//   ay_a0/b0/c0[7:0]      chip 0 channel levels
//   ay_a1/b1/c1[7:0]      chip 1 channel levels
//   beeper                beeper/tape-out bit
//   sample_l/r[SUM_W-1:0] latched mixed samples
//   sample_valid          one-cycle pulse when samples update
//   dac_l/r               sigma-delta bitstreams

module ay_stereo_mixer_dac #(
  parameter int SUM_W = 11
) (
  input  logic             clk28,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       stereo_mode,
  input  logic [7:0]       ay_a0,
  input  logic [7:0]       ay_b0,
  input  logic [7:0]       ay_c0,
  input  logic [7:0]       ay_a1,
  input  logic [7:0]       ay_b1,
  input  logic [7:0]       ay_c1,
  input  logic             beeper,
  output logic [SUM_W-1:0] sample_l,
  output logic [SUM_W-1:0] sample_r,
  output logic             sample_valid,
  output logic             dac_l,
  output logic             dac_r
);

  typedef enum logic [2:0] {K_A, K_B, K_C, K_BEEP, K_NONE} kind_t;

  logic [2:0]       slot;
  logic [1:0]       mode_q;
  logic [1:0]       mode_eff;
  logic [SUM_W-1:0] acc_l, acc_r;
  logic [SUM_W-1:0] sd_l, sd_r;
  logic [7:0]       chan_v;
  kind_t            kind;
  logic [1:0]       w_l, w_r;
  logic [SUM_W-1:0] v_ext, add_l, add_r;
  logic [SUM_W:0]   sd_sum_l, sd_sum_r;

  // Slot 0 uses the live mode so the frame being started already sees the
  // value that is latched on this edge; later slots use the latched copy.
  assign mode_eff = (slot == 3'd0) ? stereo_mode : mode_q;

  always_comb begin
    chan_v = 8'd0;
    kind   = K_NONE;
    case (slot)
      3'd0: begin chan_v = ay_a0; kind = K_A; end
      3'd1: begin chan_v = ay_b0; kind = K_B; end
      3'd2: begin chan_v = ay_c0; kind = K_C; end
      3'd3: begin chan_v = ay_a1; kind = K_A; end
      3'd4: begin chan_v = ay_b1; kind = K_B; end
      3'd5: begin chan_v = ay_c1; kind = K_C; end
      3'd6: begin
`ifdef AY_MIXER_BEEPER_EN
        chan_v = beeper ? 8'hFF : 8'h00;
`else
        // beeper has no effect in this build
        chan_v = {8{beeper}} & 8'h00;
`endif
        kind = K_BEEP;
      end
      default: begin chan_v = 8'd0; kind = K_NONE; end
    endcase
  end

  // Per-slot (left, right) weights; mode 3 falls into the mono branch.
  always_comb begin
    w_l = 2'd1;
    w_r = 2'd1;
    case (kind)
      K_A: if (mode_eff == 2'd1 || mode_eff == 2'd2) begin w_l = 2'd2; w_r = 2'd0; end
      K_B: if (mode_eff == 2'd2) begin w_l = 2'd0; w_r = 2'd2; end
      K_C: if (mode_eff == 2'd1) begin w_l = 2'd0; w_r = 2'd2; end
      K_BEEP: begin w_l = 2'd1; w_r = 2'd1; end
      default: begin w_l = 2'd0; w_r = 2'd0; end
    endcase
  end

  assign v_ext = {{(SUM_W-8){1'b0}}, chan_v};

  always_comb begin
    add_l = '0;
    add_r = '0;
    case (w_l)
      2'd1:    add_l = v_ext;
      2'd2:    add_l = {v_ext[SUM_W-2:0], 1'b0};
      default: add_l = '0;
    endcase
    case (w_r)
      2'd1:    add_r = v_ext;
      2'd2:    add_r = {v_ext[SUM_W-2:0], 1'b0};
      default: add_r = '0;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      slot         <= 3'd0;
      mode_q       <= 2'd0;
      acc_l        <= '0;
      acc_r        <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
    end else begin
      slot         <= slot + 3'd1;
      sample_valid <= (slot == 3'd7);
      if (slot == 3'd0) mode_q <= stereo_mode;
      if (slot == 3'd7) begin
        sample_l <= en ? acc_l : '0;
        sample_r <= en ? acc_r : '0;
        acc_l    <= '0;
        acc_r    <= '0;
      end else begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
      end
    end
  end

  // First-order sigma-delta: the carry out of the wrapping accumulator is the bit.
  assign sd_sum_l = {1'b0, sd_l} + {1'b0, sample_l};
  assign sd_sum_r = {1'b0, sd_r} + {1'b0, sample_r};

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sd_l  <= '0;
      sd_r  <= '0;
      dac_l <= 1'b0;
      dac_r <= 1'b0;
    end else begin
      sd_l  <= sd_sum_l[SUM_W-1:0];
      sd_r  <= sd_sum_r[SUM_W-1:0];
      dac_l <= sd_sum_l[SUM_W];
      dac_r <= sd_sum_r[SUM_W];
    end
  end

endmodule

// File: tb/tb_ay_stereo_mixer_dac.sv
// tb/tb_ay_stereo_mixer_dac.sv - directed self-checking bench for ay_stereo_mixer_dac

module tb_ay_stereo_mixer_dac;

  localparam int SUM_W = 11;
`ifdef AY_MIXER_BEEPER_EN
  localparam int FULL_MONO = 1785;
`else
  localparam int FULL_MONO = 1530;
`endif

  logic             clk28 = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       stereo_mode = 2'd0;
  logic [7:0]       ay_a0 = 8'd0, ay_b0 = 8'd0, ay_c0 = 8'd0;
  logic [7:0]       ay_a1 = 8'd0, ay_b1 = 8'd0, ay_c1 = 8'd0;
  logic             beeper = 1'b0;
  logic [SUM_W-1:0] sample_l, sample_r;
  logic             sample_valid, dac_l, dac_r;

  int n_checks = 0;
  int n_errors = 0;

  ay_stereo_mixer_dac #(.SUM_W(SUM_W)) dut (
    .clk28(clk28), .rst_n(rst_n), .en(en), .stereo_mode(stereo_mode),
    .ay_a0(ay_a0), .ay_b0(ay_b0), .ay_c0(ay_c0),
    .ay_a1(ay_a1), .ay_b1(ay_b1), .ay_c1(ay_c1),
    .beeper(beeper), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .dac_l(dac_l), .dac_r(dac_r)
  );

  always #5 clk28 = ~clk28;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int a0, input int b0, input int c0,
                        input int a1, input int b1, input int c1);
    ay_a0 = 8'(a0); ay_b0 = 8'(b0); ay_c0 = 8'(c0);
    ay_a1 = 8'(a1); ay_b1 = 8'(b1); ay_c1 = 8'(c1);
  endtask

  // Returns at the negedge where sample_valid is high (slot 0 is current then).
  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk28);
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic two_frames();
    wait_valid();
    wait_valid();
  endtask

  task automatic count_dac(input int cycles, output int ones_l, output int ones_r);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk28);
      ones_l += int'(dac_l);
      ones_r += int'(dac_r);
    end
  endtask

  int ol, or_;

  initial begin
    // Reset held with every input driven high.
    en = 1'b1; stereo_mode = 2'd3; beeper = 1'b1;
    set_ch(255, 255, 255, 255, 255, 255);
    repeat (5) @(negedge clk28);
    check("rst_sample_l", int'(sample_l), 0);
    check("rst_sample_r", int'(sample_r), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_dac_l", int'(dac_l), 0);
    check("rst_dac_r", int'(dac_r), 0);

    // First sample_valid appears after the 8th edge following release.
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk28);
      if (i == 7) check("first_valid_early", int'(sample_valid), 0);
      if (i == 8) begin
        check("first_valid", int'(sample_valid), 1);
        check("first_sample_l", int'(sample_l), FULL_MONO);
        check("first_sample_r", int'(sample_r), FULL_MONO);
      end
      if (i == 9) check("first_valid_pulse", int'(sample_valid), 0);
    end

    // Mono, all channels 100.
    beeper = 1'b0; stereo_mode = 2'd0;
    set_ch(100, 100, 100, 100, 100, 100);
    two_frames();
    check("mono600_l", int'(sample_l), 600);
    check("mono600_r", int'(sample_r), 600);

    // Mode change mid-frame: current frame mono, next frame ABC.
    set_ch(10, 20, 30, 0, 0, 0);
    two_frames();
    check("mono60_l", int'(sample_l), 60);
    repeat (3) @(negedge clk28);
    stereo_mode = 2'd1;
    wait_valid();
    check("chg_cur_l", int'(sample_l), 60);
    check("chg_cur_r", int'(sample_r), 60);
    wait_valid();
    check("abc_l", int'(sample_l), 40);
    check("abc_r", int'(sample_r), 80);

    stereo_mode = 2'd2;
    two_frames();
    check("acb_l", int'(sample_l), 50);
    check("acb_r", int'(sample_r), 70);

    // Full scale with beeper, mono.
    stereo_mode = 2'd0; beeper = 1'b1;
    set_ch(255, 255, 255, 255, 255, 255);
    two_frames();
    check("full_l", int'(sample_l), FULL_MONO);
    check("full_r", int'(sample_r), FULL_MONO);

    // Disabled: samples zero and bitstreams idle.
    en = 1'b0;
    two_frames();
    check("dis_l", int'(sample_l), 0);
    check("dis_r", int'(sample_r), 0);
    @(negedge clk28);
    count_dac(64, ol, or_);
    check("dis_dac_l_ones", ol, 0);
    check("dis_dac_r_ones", or_, 0);

    // Sigma-delta density: ABC, left = 2*255 + 4 + 2*255 = 1024, right = 4.
    en = 1'b1; beeper = 1'b0; stereo_mode = 2'd1;
    set_ch(255, 4, 0, 255, 0, 0);
    two_frames();
    check("sd1024_sample", int'(sample_l), 1024);
    count_dac(2048, ol, or_);
    check("sd1024_ones", ol, 1024);
    check("sd4_ones_r", or_, 4);

    // left = 2*255 + 2 = 512.
    set_ch(255, 2, 0, 0, 0, 0);
    two_frames();
    check("sd512_sample", int'(sample_l), 512);
    count_dac(2048, ol, or_);
    check("sd512_ones", ol, 512);

    // Asynchronous reset mid-frame.
    repeat (3) @(negedge clk28);
    #2 rst_n = 1'b0;
    #1 check("async_rst_l", int'(sample_l), 0);
    check("async_rst_dac", int'(dac_l), 0);
    @(negedge clk28);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ay_stereo_mixer_dac.md
Name: ay_stereo_mixer_dac

Overview:
- Consumes the six 8-bit channel levels (A/B/C of two AY chips) from the turbosound block and a beeper bit.
- Mixes them into left/right sums per the selected stereo mode, using a time-multiplexed accumulator.
- Drives two first-order sigma-delta 1-bit DAC outputs for the board's RC audio filters.
- Sits directly downstream of turbosound; its outputs go to FPGA pins.

Parameters:
- SUM_W, 11, width of the mixed sample; 6×255 + 255 = 1785 fits without overflow.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  1 = audio enabled; 0 = samples forced to 0
- stereo_mode  in  2  0 = mono, 1 = ABC, 2 = ACB, 3 = treated as mono
- ay_a0, ay_b0, ay_c0  in  8 each  chip 0 channel levels
- ay_a1, ay_b1, ay_c1  in  8 each  chip 1 channel levels
- beeper  in  1  beeper/tape-out bit
- sample_l, sample_r  out  SUM_W  latched mixed samples
- sample_valid  out  1  one-cycle pulse when samples update
- dac_l, dac_r  out  1  sigma-delta bitstreams

Behaviour:
- Reset: slot = 0, accumulators = 0, sample_l/r = 0, sample_valid = 0, sigma-delta accumulators = 0, dac_l/r = 0.
- Slot counter: 3 bits, increments every clk28, wraps 7 → 0. One frame = 8 cycles, giving a 3.5 MHz sample rate.
- stereo_mode is latched at slot 0. A mid-frame change takes effect at the next frame.
- Slots 0–5 process channels a0, b0, c0, a1, b1, c1. Each slot adds wL×v to acc_l and wR×v to acc_r.
- Weights (wL, wR):
  - mono: A (1,1), B (1,1), C (1,1)
  - ABC: A (2,0), B (1,1), C (0,2)
  - ACB: A (2,0), C (1,1), B (0,2)
- Weight 2 is a left shift by 1; weight 0 adds 0. Channel values are sampled in their own slot only.
- Slot 6: if beeper = 1, add 255 to both accumulators (see Optional Feature). Otherwise add 0.
- Slot 7:
  - sample_l <= en ? acc_l : 0; sample_r likewise.
  - sample_valid <= 1 for exactly the following cycle.
  - Both accumulators clear to 0 on the same edge.
- Latency: a value present during its slot is reflected in sample_l/r on the cycle after slot 7.
- Width: accumulators are SUM_W bits, unsigned. The maximum is 1785, so no saturation logic is required. Maximum per output per frame: mono 1785, ABC/ACB 1785.
- Sigma-delta (per channel, every clk28): {carry, sd[SUM_W-1:0]} <= sd + sample; dac <= carry (registered).
  - Ones density = sample / 2^SUM_W.
  - sample = 0 gives a constant 0.
  - Accumulator wrap is the intended carry mechanism.
- Reset mid-frame: all state returns to reset values asynchronously; the slot restarts at 0 after reset release.

Optional Feature:
- Macro: AY_MIXER_BEEPER_EN.
- Defined: slot 6 adds 255 to both accumulators when beeper = 1.
- Undefined: slot 6 adds 0; the beeper port is present but ignored.

Test Plan:
- Reset held, all inputs 0xFF → all outputs 0. After release, the first sample_valid pulse occurs on the cycle after slot 7.
- Mono, en = 1, all six channels 100, beeper = 0 → sample_l = sample_r = 600.
- ABC mode, a0 = 10, b0 = 20, c0 = 30, chip 1 = 0 → sample_l = 40, sample_r = 80. Same inputs in ACB → sample_l = 50, sample_r = 70.
- stereo_mode changed from mono to ABC at slot 3 → the current frame stays mono; the next frame uses ABC.
- All channels 255, beeper = 1, mono:
  - with AY_MIXER_BEEPER_EN → sample = 1785;
  - without → 1530;
  - en = 0 → sample = 0, dac stays 0.
- sample_l fixed at 1024 → dac_l ones density exactly 1/2 over 2048 cycles. sample_l = 512 → exactly 512 ones per 2048 cycles.
